// File: rtl/fp_divider32_pkg.sv
// Shared widths, bias and FSM encoding for the iterative FP divider.
// The build option FPD_DIVZERO_EN is consumed by fp_divider32.sv.
package fp_divider32_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;
    localparam int ITER   = MANT_W + 2;
    localparam int CNT_W  = 5;

    localparam logic [EXP_W-1:0] BIAS_EXP = EXP_W'(BIAS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2
    } state_t;

endpackage

// File: rtl/fp_divider32_if.sv
// Start/busy/done handshake bundle with operands and quotient.
interface fp_divider32_if;

    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] q;

    modport master (output start, a, b, input busy, done, q);
    modport slave  (input start, a, b, output busy, done, q);

endinterface

// File: rtl/fp_divider32_mant_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module fp_divider32_mant_div_step
    import fp_divider32_pkg::*;
(
    input  logic [MANT_W+1:0] r,
    input  logic [MANT_W:0]   d,
    output logic              qbit,
    output logic [MANT_W+1:0] r_next
);

    logic [MANT_W+1:0] d_ext;
    logic [MANT_W+1:0] diff;

    assign d_ext  = {1'b0, d};
    assign qbit   = (r >= d_ext);
    assign diff   = qbit ? (r - d_ext) : r;
    // diff < d always holds, so the shift never loses a set bit
    assign r_next = diff << 1;

endmodule

// File: rtl/fp_divider32.sv
// Iterative single-precision divider, one quotient bit per clock, truncating.
// Build option: FPD_DIVZERO_EN short-circuits a zero divisor to signed infinity.
//
// state  | meaning
// IDLE   | waiting for start; operands captured on the accepting edge
// DIVIDE | ITER restoring steps, down-counter runs to terminal count 1
// NORM   | normalise quotient, register q, pulse done
module fp_divider32
    import fp_divider32_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    fp_divider32_if.slave   bus
);

    state_t state, state_n;

    logic              sign_r;
    logic [EXP_W-1:0]  exp_r;
    logic [MANT_W+1:0] rem_r;
    logic [MANT_W:0]   div_r;
    logic [MANT_W+1:0] quo_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              dz_r;
    logic              done_r;
    logic [31:0]       q_r;
    logic              busy_c;
    logic              b_zero;
    logic              qbit;
    logic [MANT_W+1:0] rem_next;

`ifdef FPD_DIVZERO_EN
    assign b_zero = (bus.b[30:0] == 31'd0);
`else
    assign b_zero = 1'b0;
`endif

    fp_divider32_mant_div_step u_step (
        .r      (rem_r),
        .d      (div_r),
        .qbit   (qbit),
        .r_next (rem_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_n = b_zero ? NORM : DIVIDE;
            end
            DIVIDE: begin
                busy_c = 1'b1;
                if (cnt_r == CNT_W'(1)) state_n = NORM;
            end
            NORM: begin
                busy_c  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r <= 1'b0;
            exp_r  <= '0;
            rem_r  <= '0;
            div_r  <= '0;
            quo_r  <= '0;
            cnt_r  <= '0;
            dz_r   <= 1'b0;
            done_r <= 1'b0;
            q_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign_r <= bus.a[31] ^ bus.b[31];
                        exp_r  <= bus.a[30:23] - bus.b[30:23] + BIAS_EXP;
                        rem_r  <= {2'b01, bus.a[MANT_W-1:0]};
                        div_r  <= {1'b1, bus.b[MANT_W-1:0]};
                        quo_r  <= '0;
                        cnt_r  <= CNT_W'(ITER);
                        dz_r   <= b_zero;
                    end
                end
                DIVIDE: begin
                    rem_r <= rem_next;
                    quo_r <= {quo_r[MANT_W:0], qbit};
                    cnt_r <= cnt_r - 1'b1;
                end
                NORM: begin
                    done_r <= 1'b1;
                    if (dz_r)
                        q_r <= {sign_r, 8'hFF, 23'd0};
                    else if (quo_r[MANT_W+1])
                        q_r <= {sign_r, exp_r, quo_r[MANT_W:1]};
                    else
                        q_r <= {sign_r, exp_r - 8'd1, quo_r[MANT_W-1:0]};
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_r;
    assign bus.q    = q_r;

endmodule

// File: doc/fp_divider32.md
Name: fp_divider32

Overview:
- Iterative single-precision (IEEE-754 layout) floating-point divider computing Q = A / B; the inverse of the team's pipelined FP multiplier and used alongside it in the arithmetic datapath.
- Operates on the same simplified model as the multiplier: no special cases (except the optional divide-by-zero path), no rounding, exponent arithmetic modulo 256.
- Uses a start/busy/done handshake and a restoring mantissa division, one quotient bit per clock.

Parameters:
- EXP_W, 8, exponent field width.
- MANT_W, 23, stored mantissa width (hidden bit excluded).
- BIAS, 127, exponent bias.
- ITER, 25, restoring-division iterations (MANT_W+2).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- A  input  32  dividend {sign, exp[7:0], mant[22:0]}.
- B  input  32  divisor, same format.
- busy  output  1  high while an operation is in progress (DIVIDE, NORM).
- done  output  1  one-cycle pulse; Q is valid from this cycle on.
- Q  output  32  quotient; holds its value until the next done.

Behaviour:
- Reset: a synchronous, active-high reset on rising clk sets state=IDLE, busy=0, done=0, Q=0, and clears all internal registers. Reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE -> DIVIDE -> NORM -> IDLE.
- IDLE: start=1 at an edge (edge 0) triggers the following register loads:
  - sign_r = A[31]^B[31].
  - exp_r = A[30:23] - B[30:23] + BIAS, 8-bit wrap, carry discarded.
  - remainder R = {1'b0, 1, A[22:0]} (25 bits).
  - divisor D = {1, B[22:0]}.
  - quotient q = 0; count = 0.
  - Next state is DIVIDE and busy goes high.
- DIVIDE, one iteration per edge (edges 1..25):
  - If R >= D: qbit = 1, R = R - D; otherwise qbit = 0.
  - q = {q[23:0], qbit}; R = R << 1; count++.
  - After the edge where count reaches ITER, the next state is NORM.
- NORM (edge 26):
  - If q[24] = 1: Q = {sign_r, exp_r, q[23:1]}.
  - Else: Q = {sign_r, exp_r - 1 (8-bit wrap), q[22:0]}.
  - Truncation only.
  - done = 1, busy = 0, next state IDLE.
- Latency: done is high in the cycle after edge 26, i.e. 26 clocks after the start-sampling edge. done is high for exactly one cycle.
- start while busy is ignored; A/B changes while busy have no effect, because operands are captured at edge 0.
- Back-to-back: start high during the done cycle is accepted, since the FSM is already in IDLE.
- rst and start at the same edge: rst wins.

Optional Feature:
- Macro: FPD_DIVZERO_EN.
- Defined:
  - At the start edge, if B[30:0] == 0, the FSM skips DIVIDE and goes straight to NORM.
  - At edge 1, Q = {A[31]^B[31], 8'hFF, 23'd0} (signed infinity) and done pulses; latency is 1 clock.
- Undefined: no detection. B = ±0 is divided as mantissa 1.0 with exponent 0, following the normal datapath.

Decomposition:
- Shared include file fp_defs.vh: EXP_W, MANT_W, BIAS, ITER, state encodings (IDLE=2'd0, DIVIDE=2'd1, NORM=2'd2).
- One sub-module, mant_div_step: combinational single restoring step taking R and D and producing qbit and R_next. The top block owns the FSM, counter and registers.

Test Plan:
- A=0x40C00000 (6.0), B=0x40000000 (2.0), start pulse -> after 26 clocks done=1, Q=0x40400000; busy high for cycles 1..26.
- A=0x3F800000 (1.0), B=0x40400000 (3.0) -> Q=0x3EAAAAAA (truncated, not 0x3EAAAAAB).
- A=0xC0F00000 (-7.5), B=0x40200000 (2.5) -> Q=0xC0400000 (-3.0).
- Start at cycle 0 with 6.0/2.0, second start with other operands at cycle 10 -> ignored, Q=0x40400000 at cycle 26. Repeat with rst at cycle 12 -> busy=0, Q=0, no done pulse through cycle 40.
- Back-to-back: 6.0/2.0, then start with A=0x3F800000, B=0x40400000 during the done cycle -> second done 26 clocks later with Q=0x3EAAAAAA.
- A=0x3F800000, B=0x80000000:
  - With FPD_DIVZERO_EN: done one clock after start, Q=0xFF800000.
  - Without FPD_DIVZERO_EN: done after 26 clocks, Q=0xFF000000.
